// File: rtl/nto1_rr_sel_arbiter_if.sv
// Control bundle between N sources, the arbiter and the downstream consumer.
// The arbiter takes the slave view; the source/consumer side takes master.
interface nto1_rr_sel_arbiter_if #(
    parameter int N = 16
);
    localparam int SW = $clog2(N);

    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic [SW-1:0] sel;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;

    modport slave (
        input  req_valid,
        input  req_last,
        input  out_ready,
        output req_ready,
        output sel,
        output out_valid,
        output out_last,
        output busy
    );

    modport master (
        output req_valid,
        output req_last,
        output out_ready,
        input  req_ready,
        input  sel,
        input  out_valid,
        input  out_last,
        input  busy
    );
endinterface

// File: rtl/nto1_rr_sel_arbiter.sv
// Packet-aware round-robin arbiter driving the select of an N-to-1 data mux.
// Grant is held from the first beat until the last beat is accepted.
module nto1_rr_sel_arbiter #(
    parameter int N = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    nto1_rr_sel_arbiter_if.slave     bus
);
    localparam int SW = $clog2(N);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] win;
    logic          found;
    int            idx;

    // Rotating scan starting at ptr; the first requester found wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx[SW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bus.busy             = 1'b1;
                bus.out_valid        = bus.req_valid[sel_q];
                bus.out_last         = bus.req_last[sel_q];
                bus.req_ready[sel_q] = bus.out_ready;
                // Release only on an accepted last beat.
                if (bus.req_valid[sel_q] && bus.out_ready &&
                    bus.req_last[sel_q]) begin
                    state_d = IDLE;
                    ptr_d   = (sel_q == SW'(N - 1)) ? '0 : sel_q + 1'b1;
                end
            end
        endcase
    end

    assign bus.sel = sel_q;
endmodule

// File: tb/tb_nto1_rr_sel_arbiter.sv
// Directed bench for the round-robin select arbiter (N=4 and N=5 instances).
// Vector table first, then hand-written reset and wrap sequences.
module tb_nto1_rr_sel_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    nto1_rr_sel_arbiter_if #(.N(4)) a_if ();
    nto1_rr_sel_arbiter_if #(.N(5)) b_if ();

    nto1_rr_sel_arbiter #(.N(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    nto1_rr_sel_arbiter #(.N(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    typedef struct {
        logic       rst;
        logic [3:0] rv;
        logic [3:0] rl;
        logic       ordy;
        logic [1:0] sel;
        logic [3:0] rdy;
        logic       ov;
        logic       ol;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rs, input logic [3:0] rv, input logic [3:0] rl,
        input logic ordy, input logic [1:0] sel, input logic [3:0] rdy,
        input logic ov, input logic ol, input logic busy);
        vec_t v;
        v.rst = rs; v.rv = rv; v.rl = rl; v.ordy = ordy;
        v.sel = sel; v.rdy = rdy; v.ov = ov; v.ol = ol; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input vec_t v);
        check({tag, " sel"},  32'(a_if.sel),       32'(v.sel));
        check({tag, " rdy"},  32'(a_if.req_ready), 32'(v.rdy));
        check({tag, " ov"},   32'(a_if.out_valid), 32'(v.ov));
        check({tag, " ol"},   32'(a_if.out_last),  32'(v.ol));
        check({tag, " busy"}, 32'(a_if.busy),      32'(v.busy));
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        rst            = v.rst;
        a_if.req_valid = v.rv;
        a_if.req_last  = v.rl;
        a_if.out_ready = v.ordy;
        #1;
        check_a(tag, v);
    endtask

    task automatic step_b(input string tag, input logic [4:0] rv,
        input logic [4:0] rl, input logic ordy, input logic [2:0] sel,
        input logic [4:0] rdy, input logic ov, input logic busy);
        @(negedge clk);
        b_if.req_valid = rv;
        b_if.req_last  = rl;
        b_if.out_ready = ordy;
        #1;
        check({tag, " sel"},  32'(b_if.sel),       32'(sel));
        check({tag, " rdy"},  32'(b_if.req_ready), 32'(rdy));
        check({tag, " ov"},   32'(b_if.out_valid), 32'(ov));
        check({tag, " busy"}, 32'(b_if.busy),      32'(busy));
    endtask

    initial begin
        a_if.req_valid = '0;
        a_if.req_last  = '0;
        a_if.out_ready = 1'b0;
        b_if.req_valid = '0;
        b_if.req_last  = '0;
        b_if.out_ready = 1'b0;

        // reset, then source 2 three-beat packet
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 2, 4'b0100, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 2, 4'b0100, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 2, 4'b0100, 1, 1, 1));
        // ptr=3: sources 0 and 3 -> 3 wins
        vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 2, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 3, 4'b1000, 1, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 3, 4'b0000, 0, 0, 0));
        // all request single beats: order 0,1,2,3,0
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 3, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0001, 1, 1, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 4'b0010, 1, 1, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 2, 4'b0100, 1, 1, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 2, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 3, 4'b1000, 1, 1, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 3, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0001, 1, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
        // source 1 with stalls and valid gaps; others ignored
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 1, 4'b0010, 1, 0, 1));
        vecs.push_back(mk(0, 4'b1101, 4'b1101, 0, 1, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 4'b1101, 4'b0000, 0, 1, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b0010, 1, 0, 1));
        vecs.push_back(mk(0, 4'b1101, 4'b0010, 1, 1, 4'b0010, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 1, 4'b0010, 1, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0, 0));
        // source 0 single beat from ptr=2, busy for one cycle
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 0, 4'b0001, 1, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
        // ptr=1: sources 0 and 1 -> 1 wins
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 1, 4'b0010, 1, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("row%0d", i), vecs[i]);

        // reset in the middle of a 4-beat packet from source 3
        apply("mr0", mk(0, 4'b1000, 4'b0000, 1, 1, 4'b0000, 0, 0, 0));
        apply("mr1", mk(0, 4'b1000, 4'b0000, 1, 3, 4'b1000, 1, 0, 1));
        apply("mr2", mk(0, 4'b1000, 4'b0000, 1, 3, 4'b1000, 1, 0, 1));
        rst = 1'b1;
        #1;
        check_a("mr_rst", mk(1, 4'b1000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
        apply("mr3", mk(1, 4'b1000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
        apply("mr4", mk(0, 4'b1000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
        apply("mr5", mk(0, 4'b1000, 4'b1000, 1, 3, 4'b1000, 1, 1, 1));
        apply("mr6", mk(0, 4'b1010, 4'b1010, 1, 3, 4'b0000, 0, 0, 0));
        apply("mr7", mk(0, 4'b1010, 4'b1010, 1, 1, 4'b0010, 1, 1, 1));
        apply("mr8", mk(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0, 0));

        // N=5: winner 4 wraps ptr to 0
        step_b("b0", 5'b10000, 5'b10000, 1, 0, 5'b00000, 0, 0);
        step_b("b1", 5'b10000, 5'b10000, 1, 4, 5'b10000, 1, 1);
        step_b("b2", 5'b01001, 5'b01001, 1, 4, 5'b00000, 0, 0);
        step_b("b3", 5'b01001, 5'b01001, 1, 0, 5'b00001, 1, 1);
        step_b("b4", 5'b01001, 5'b01001, 1, 0, 5'b00000, 0, 0);
        step_b("b5", 5'b01001, 5'b01001, 1, 3, 5'b01000, 1, 1);
        step_b("b6", 5'b00000, 5'b00000, 0, 3, 5'b00000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
